// File: rtl/mask_row_writer.sv
// mask_row_writer
//   Packs a stream of binary mask pixels into one BRAM word per image row and
//   writes a full frame of V_RES rows. Once the last row is written, the
//   accumulator is asked to run. The module then waits for acc_done to go
//   high and low again before it accepts a new frame. If a frame starts while
//   the accumulator owns the BRAM, that frame is dropped and reported.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : asynchronous, active-high reset
//   s_valid    : pixel qualifier; s_pix/s_sof/s_eol are only looked at when 1
//   s_pix      : mask pixel value
//   s_sof      : first pixel of a frame (row 0, column 0)
//   s_eol      : last pixel of a line
//   ena, wea   : BRAM port-A enable / write enable (one-cycle strobe per row)
//   addra      : BRAM row address
//   dina       : packed row, column 0 in bit 0
//   run_acc    : frame-ready request to the accumulator
//   acc_done   : accumulator completion level
//   frame_drop : one-cycle pulse when an incoming frame is discarded
module mask_row_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_pix,
    input  logic             s_sof,
    input  logic             s_eol,
    output logic             ena,
    output logic             wea,
    output logic [8:0]       addra,
    output logic [H_RES-1:0] dina,
    output logic             run_acc,
    input  logic             acc_done,
    output logic             frame_drop
);

    localparam int COL_W = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    localparam logic [8:0]       ROW_LAST = 9'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, FILL, WAIT_ACC, RELEASE} state_t;

    state_t           state_reg, state_next;
    logic [8:0]       row_reg, row_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [H_RES-1:0] shift_reg, shift_next;
    logic             skip_reg, skip_next;   // discarding the tail of a long line
    logic             wr_reg, wr_next;
    logic [8:0]       addr_reg, addr_next;
    logic [H_RES-1:0] data_reg, data_next;
    logic             run_reg, run_next;
    logic             drop_reg, drop_next;

    // An s_sof accepted in IDLE or FILL restarts the frame. The pixel is then
    // handled as column 0 of row 0 on top of an empty row, so the row position
    // and row contents seen by the rest of the logic are replaced here.
    logic             restart;
    logic [8:0]       eff_row;
    logic [COL_W-1:0] eff_col;
    logic [H_RES-1:0] eff_shift;
    logic [H_RES-1:0] packed_row;
    logic             row_done;
    logic             take;

    assign restart   = s_valid && s_sof && ((state_reg == IDLE) || (state_reg == FILL));
    assign eff_row   = restart ? 9'd0 : row_reg;
    assign eff_col   = restart ? '0 : col_reg;
    assign eff_shift = restart ? '0 : shift_reg;
    assign row_done  = (eff_col == COL_LAST) || s_eol;
    assign take      = s_valid && (restart || ((state_reg == FILL) && !skip_reg));

    // Row contents including the pixel being accepted now. Bits above the
    // current column are still zero because the row is cleared after each
    // write, so a short line goes out with its upper bits at 0.
    generate
        for (genvar gi = 0; gi < H_RES; gi++) begin : g_pack
            assign packed_row[gi] = eff_shift[gi] | (s_pix && (eff_col == COL_W'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            col_reg   <= '0;
            shift_reg <= '0;
            skip_reg  <= 1'b0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            run_reg   <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            col_reg   <= col_next;
            shift_reg <= shift_next;
            skip_reg  <= skip_next;
            wr_reg    <= wr_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            run_reg   <= run_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        shift_next = shift_reg;
        skip_next  = skip_reg;
        wr_next    = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        run_next   = 1'b0;
        drop_next  = 1'b0;

        case (state_reg)
            IDLE, FILL: begin
                // The tail of a long line is swallowed up to and including
                // its s_eol, so it never starts a row of its own.
                if (s_valid && !s_sof && (state_reg == FILL) && skip_reg && s_eol) begin
                    skip_next = 1'b0;
                end
                if (take) begin
                    skip_next = 1'b0;
                    if (row_done) begin
                        wr_next    = 1'b1;
                        addr_next  = eff_row;
                        data_next  = packed_row;
                        shift_next = '0;
                        col_next   = '0;
                        // A row cut off at full width without s_eol leaves
                        // excess pixels to discard.
                        skip_next  = !s_eol;
                        if (eff_row == ROW_LAST) begin
                            state_next = WAIT_ACC;
                            row_next   = '0;
                            skip_next  = 1'b0;
                        end else begin
                            state_next = FILL;
                            row_next   = eff_row + 9'd1;
                        end
                    end else begin
                        state_next = FILL;
                        row_next   = eff_row;
                        shift_next = packed_row;
                        col_next   = eff_col + COL_W'(1);
                    end
                end
            end
            WAIT_ACC: begin
                run_next = 1'b1;
                if (s_valid && s_sof) begin
                    drop_next = 1'b1;
                end
                // acc_done only counts once the request is actually visible,
                // so a stale level from the previous frame cannot end it early.
                if (run_reg && acc_done) begin
                    state_next = RELEASE;
                    run_next   = 1'b0;
                end
            end
            RELEASE: begin
                if (s_valid && s_sof) begin
                    drop_next = 1'b1;
                end
                if (!acc_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ena        = wr_reg;
    assign wea        = wr_reg;
    assign addra      = addr_reg;
    assign dina       = data_reg;
    assign run_acc    = run_reg;
    assign frame_drop = drop_reg;

endmodule
